// File: rtl/match_event_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : match_event_pkg
//  Description : Shared types and default widths for the match event queue.
//                match_rec_t is the {pkt_id, word_idx} event record and
//                state_t is the packet-tracking state machine encoding.
//  Options     : MATCH_WORD_CAPTURE_EN (see match_event_queue)
//  Revision    : 1.0 - initial release
// ============================================================================
package match_event_pkg;

    localparam int c_FIFO_DEPTH   = 8;
    localparam int c_ADDR_W       = 3;
    localparam int c_PKT_ID_W     = 16;
    localparam int c_IDX_W        = 16;
    localparam int c_MATCH_WORD_W = 32;
    localparam int c_TOTAL_W      = 16;

    typedef struct packed {
        logic [c_PKT_ID_W-1:0] pkt_id;
        logic [c_IDX_W-1:0]    word_idx;
    } match_rec_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        HIT    = 2'd2,
        CLR    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/match_event_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : match_event_queue_if
//  Description : Bundle of word-stream, comparator-rearm and host FIFO
//                signals for match_event_queue.
//                master : drives word_valid/sop/eop/match/rd_en
//                slave  : drives clear/rd_data/empty/full/fifo_count/
//                         overflow/match_total
//  Options     : MATCH_WORD_CAPTURE_EN adds match_word (in) and
//                rd_match_word (out)
//  Revision    : 1.0 - initial release
// ============================================================================
interface match_event_queue_if
    import match_event_pkg::*;
#(
    parameter int ADDR_W   = c_ADDR_W,
    parameter int PKT_ID_W = c_PKT_ID_W,
    parameter int IDX_W    = c_IDX_W
) ();

    logic                      word_valid;
    logic                      sop;
    logic                      eop;
    logic                      match;
    logic                      rd_en;
    logic                      clear;
    logic [PKT_ID_W+IDX_W-1:0] rd_data;
    logic                      empty;
    logic                      full;
    logic [ADDR_W:0]           fifo_count;
    logic                      overflow;
    logic [c_TOTAL_W-1:0]      match_total;
`ifdef MATCH_WORD_CAPTURE_EN
    logic [c_MATCH_WORD_W-1:0] match_word;
    logic [c_MATCH_WORD_W-1:0] rd_match_word;
`endif

    modport master (
        output word_valid, sop, eop, match, rd_en,
        input  clear, rd_data, empty, full, fifo_count, overflow, match_total
`ifdef MATCH_WORD_CAPTURE_EN
        , output match_word
        , input  rd_match_word
`endif
    );

    modport slave (
        input  word_valid, sop, eop, match, rd_en,
        output clear, rd_data, empty, full, fifo_count, overflow, match_total
`ifdef MATCH_WORD_CAPTURE_EN
        , input  match_word
        , output rd_match_word
`endif
    );

endinterface
`default_nettype wire

// File: rtl/match_event_queue_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : match_fifo
//  Description : Synchronous first-word-fall-through FIFO of event records.
//                The head entry is presented on data_o whenever the FIFO is
//                non-empty; data_o reads zero while empty.
//  Ports       : clk, n_rst (async, active-low)
//                push_i/data_i - write request and record
//                pop_i         - consume head (ignored while empty)
//                data_o        - head record
//                count_o/full_o/empty_o - occupancy
//                drop_o        - push rejected because full with no pop
//  Revision    : 1.0 - initial release
// ============================================================================
module match_fifo
    import match_event_pkg::*;
#(
    parameter int DEPTH  = c_FIFO_DEPTH,
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_PKT_ID_W + c_IDX_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              drop_o
);

    localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_full    = (count_q == c_DEPTH_CNT);
    assign w_empty   = (count_q == '0);
    // A simultaneous pop frees the slot, so a push into a full FIFO still
    // lands; a pop on an empty FIFO has nothing to remove.
    assign w_push_ok = push_i && (!w_full || pop_i);
    assign w_pop_ok  = pop_i && !w_empty;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (w_pop_ok) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
                2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the output is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = w_empty ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign drop_o  = push_i && !w_push_ok;

endmodule
`default_nettype wire

// File: rtl/match_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : match_event_queue
//  Description : Tracks the word-delimited packet stream alongside the string
//                comparator's match flag, records one {pkt_id, word_idx}
//                event per matching packet into a FWFT FIFO, and pulses
//                clear for one cycle after every packet to re-arm the
//                comparator.
//  Ports       : clk, n_rst (async, active-low)
//                bus (match_event_queue_if.slave):
//                  word_valid/sop/eop/match - packet stream + match flag
//                  rd_en                    - pop head record
//                  clear                    - comparator re-arm pulse
//                  rd_data/empty/full/fifo_count - event FIFO head/status
//                  overflow                 - sticky record-dropped flag
//                  match_total              - saturating matching-packet count
//  Options     : MATCH_WORD_CAPTURE_EN - also captures the comparator word
//                (match_word) on the hit and returns it on rd_match_word.
//  Revision    : 1.0 - initial release
// ============================================================================
module match_event_queue
    import match_event_pkg::*;
#(
    parameter int FIFO_DEPTH = c_FIFO_DEPTH,
    parameter int ADDR_W     = c_ADDR_W,
    parameter int PKT_ID_W   = c_PKT_ID_W,
    parameter int IDX_W      = c_IDX_W
) (
    input  logic               clk,
    input  logic               n_rst,
    match_event_queue_if.slave bus
);

    localparam int c_REC_W = PKT_ID_W + IDX_W;
`ifdef MATCH_WORD_CAPTURE_EN
    localparam int c_FIFO_W = c_REC_W + c_MATCH_WORD_W;
`else
    localparam int c_FIFO_W = c_REC_W;
`endif

    state_t                state_q;
    logic [PKT_ID_W-1:0]   pkt_id_q;
    logic [IDX_W-1:0]      word_idx_q;
    logic [IDX_W-1:0]      hit_idx_q;
    logic                  clear_q;
    logic                  overflow_q;
    logic [c_TOTAL_W-1:0]  match_total_q;
`ifdef MATCH_WORD_CAPTURE_EN
    logic [c_MATCH_WORD_W-1:0] match_word_q;
    logic [c_MATCH_WORD_W-1:0] w_push_word;
`endif

    logic                  w_in_pkt;
    logic [IDX_W-1:0]      w_cur_idx;
    logic [IDX_W-1:0]      w_push_idx;
    logic                  w_push;
    logic                  w_drop;
    logic [c_FIFO_W-1:0]   w_push_data;
    logic [c_FIFO_W-1:0]   w_head;
    logic [ADDR_W:0]       w_count;
    logic                  w_full;
    logic                  w_empty;

    always_comb begin
        w_in_pkt  = (state_q == IN_PKT) || (state_q == HIT);
        // Index of the word on the bus right now; sticks at all-ones.
        w_cur_idx = (&word_idx_q) ? word_idx_q : word_idx_q + IDX_W'(1);
        // Push on the finalising word: a single-word packet with match in
        // IDLE, or eop inside a packet that already hit or hits on eop.
        w_push    = bus.word_valid &&
                    (((state_q == IDLE) && bus.sop && bus.eop && bus.match) ||
                     (w_in_pkt && !bus.sop && bus.eop &&
                      ((state_q == HIT) || bus.match)));
        if (state_q == HIT) begin
            w_push_idx = hit_idx_q;
        end else if (state_q == IDLE) begin
            w_push_idx = '0;
        end else begin
            w_push_idx = w_cur_idx;
        end
`ifdef MATCH_WORD_CAPTURE_EN
        w_push_word = (state_q == HIT) ? match_word_q : bus.match_word;
        w_push_data = {w_push_word, pkt_id_q, w_push_idx};
`else
        w_push_data = {pkt_id_q, w_push_idx};
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            pkt_id_q      <= '0;
            word_idx_q    <= '0;
            hit_idx_q     <= '0;
            clear_q       <= 1'b0;
            overflow_q    <= 1'b0;
            match_total_q <= '0;
`ifdef MATCH_WORD_CAPTURE_EN
            match_word_q  <= '0;
`endif
        end else begin
            clear_q <= 1'b0;
            // Counted even if the FIFO drops the record.
            if (w_push && (match_total_q != '1)) begin
                match_total_q <= match_total_q + c_TOTAL_W'(1);
            end
            if (w_drop) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (bus.word_valid && bus.sop) begin
                        word_idx_q <= '0;
                        if (bus.eop) begin
                            pkt_id_q <= pkt_id_q + PKT_ID_W'(1);
                            clear_q  <= 1'b1;
                            state_q  <= CLR;
                        end else if (bus.match) begin
                            hit_idx_q <= '0;
`ifdef MATCH_WORD_CAPTURE_EN
                            match_word_q <= bus.match_word;
`endif
                            state_q   <= HIT;
                        end else begin
                            state_q <= IN_PKT;
                        end
                    end
                end
                IN_PKT, HIT: begin
                    if (bus.word_valid) begin
                        if (bus.sop) begin
                            // Missing eop: abandon the packet without a record.
                            pkt_id_q <= pkt_id_q + PKT_ID_W'(1);
                            clear_q  <= 1'b1;
                            state_q  <= CLR;
                        end else begin
                            word_idx_q <= w_cur_idx;
                            if (bus.eop) begin
                                pkt_id_q <= pkt_id_q + PKT_ID_W'(1);
                                clear_q  <= 1'b1;
                                state_q  <= CLR;
                            end else if ((state_q == IN_PKT) && bus.match) begin
                                hit_idx_q <= w_cur_idx;
`ifdef MATCH_WORD_CAPTURE_EN
                                match_word_q <= bus.match_word;
`endif
                                state_q   <= HIT;
                            end
                        end
                    end
                end
                CLR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    match_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (c_FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .push_i  (w_push),
        .pop_i   (bus.rd_en),
        .data_i  (w_push_data),
        .data_o  (w_head),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty),
        .drop_o  (w_drop)
    );

    assign bus.clear       = clear_q;
    assign bus.rd_data     = w_head[c_REC_W-1:0];
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.fifo_count  = w_count;
    assign bus.overflow    = overflow_q;
    assign bus.match_total = match_total_q;
`ifdef MATCH_WORD_CAPTURE_EN
    assign bus.rd_match_word = w_head[c_FIFO_W-1:c_REC_W];
`endif

endmodule
`default_nettype wire

// File: tb/tb_match_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_match_event_queue
//  Description : Self-checking bench for match_event_queue. Packets are
//                described at packet level (length, index of first match,
//                pop-on-eop) and an event-queue model predicts the FIFO
//                contents, pkt_id sequence, match_total and overflow.
//  Options     : MATCH_WORD_CAPTURE_EN also checks rd_match_word.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_match_event_queue;
    import match_event_pkg::*;

    localparam int DEPTH = c_FIFO_DEPTH;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    match_event_queue_if bus ();

    match_event_queue dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    match_rec_t  exp_q[$];
    logic [31:0] exp_w[$];
    logic [15:0] m_pkt_id = '0;
    logic [15:0] m_total  = '0;
    logic        m_ovf    = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        bus.word_valid = 1'b0;
        bus.sop        = 1'b0;
        bus.eop        = 1'b0;
        bus.match      = 1'b0;
        bus.rd_en      = 1'b0;
`ifdef MATCH_WORD_CAPTURE_EN
        bus.match_word = '0;
`endif
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_w.delete();
        m_pkt_id = '0;
        m_total  = '0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_pop();
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(exp_w.pop_front());
        end
    endtask

    task automatic model_end_pkt(input bit hit, input int idx, input logic [31:0] w);
        match_rec_t r;
        if (hit) begin
            if (m_total != 16'hFFFF) m_total = m_total + 16'd1;
            r.pkt_id   = m_pkt_id;
            r.word_idx = 16'(idx);
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(r);
                exp_w.push_back(w);
            end else begin
                m_ovf = 1'b1;
            end
        end
        m_pkt_id = m_pkt_id + 16'd1;
    endtask

    task automatic check_status(input string tag);
        logic [63:0] head;
        head = (exp_q.size() > 0) ? 64'(exp_q[0]) : 64'd0;
        chk({tag, ".rd_data"},     64'(bus.rd_data),     head);
        chk({tag, ".fifo_count"},  64'(bus.fifo_count),  64'(exp_q.size()));
        chk({tag, ".empty"},       64'(bus.empty),       64'(exp_q.size() == 0));
        chk({tag, ".full"},        64'(bus.full),        64'(exp_q.size() == DEPTH));
        chk({tag, ".overflow"},    64'(bus.overflow),    64'(m_ovf));
        chk({tag, ".match_total"}, 64'(bus.match_total), 64'(m_total));
`ifdef MATCH_WORD_CAPTURE_EN
        chk({tag, ".rd_match_word"}, 64'(bus.rd_match_word),
            (exp_w.size() > 0) ? 64'(exp_w[0]) : 64'd0);
`endif
    endtask

    // Drive one packet. hit_at = index of first match (-1: none); later words
    // may randomly carry match too and must be ignored.
    task automatic send_pkt(input int len, input int hit_at, input bit pop_eop, input bit gaps);
        logic [31:0] hw;
        logic [31:0] mw;
        hw = '0;
        for (int i = 0; i < len; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                bus.word_valid = 1'b0;
                bus.sop        = 1'($urandom);
                bus.eop        = 1'($urandom);
                bus.match      = 1'($urandom);
                step();
            end
            mw = $urandom;
            if (i == hit_at) hw = mw;
            bus.word_valid = 1'b1;
            bus.sop        = (i == 0);
            bus.eop        = (i == len - 1);
            bus.match      = (hit_at >= 0) && (i >= hit_at) &&
                             ((i == hit_at) || ($urandom_range(0, 1) == 1));
`ifdef MATCH_WORD_CAPTURE_EN
            bus.match_word = mw;
`endif
            bus.rd_en      = pop_eop && (i == len - 1);
            step();
        end
        idle_in();
        if (pop_eop) model_pop();
        model_end_pkt(hit_at >= 0, hit_at, hw);
        chk("clear_pulse", 64'(bus.clear), 64'd1);
        check_status("post_eop");
        step();
        chk("clear_end", 64'(bus.clear), 64'd0);
    endtask

    task automatic pop_chk(input string tag);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        model_pop();
        check_status(tag);
    endtask

    initial begin
        int len;
        int hit;
        idle_in();

        // Reset state
        repeat (3) step();
        n_rst = 1'b1;
        step();
        chk("rst.clear", 64'(bus.clear), 64'd0);
        check_status("rst");

        // No-match packet then match on word 0: record carries pkt_id 1
        send_pkt(4, -1, 1'b0, 1'b0);
        send_pkt(3, 0, 1'b0, 1'b0);
        pop_chk("pop1");
        // 5 words, match on word 3
        send_pkt(5, 3, 1'b0, 1'b0);
        pop_chk("pop2");
        // Single-word packets, with and without match; match on eop word
        send_pkt(1, 0, 1'b0, 1'b0);
        send_pkt(1, -1, 1'b0, 1'b0);
        send_pkt(4, 3, 1'b0, 1'b0);
        pop_chk("pop3");
        pop_chk("pop4");
        // rd_en on empty is ignored
        pop_chk("pop_empty");

        // Abort: match then a second sop without eop
        bus.word_valid = 1'b1; bus.sop = 1'b1; step();
        bus.sop = 1'b0; step();
        bus.match = 1'b1; step();
        bus.match = 1'b0; step();
        bus.sop = 1'b1; step();
        idle_in();
        m_pkt_id = m_pkt_id + 16'd1;
        chk("abort.clear", 64'(bus.clear), 64'd1);
        check_status("abort");
        step();
        chk("abort.clear_end", 64'(bus.clear), 64'd0);

        // Push+pop while empty: push only
        send_pkt(2, 1, 1'b1, 1'b0);
        pop_chk("pop5");

        // Fill to full, push+pop while full, then overflow, then drain
        for (int k = 0; k < DEPTH; k++) begin
            len = $urandom_range(1, 6);
            send_pkt(len, $urandom_range(0, len - 1), 1'b0, 1'b1);
        end
        send_pkt(3, 2, 1'b1, 1'b0);
        chk("full_pushpop.overflow", 64'(bus.overflow), 64'd0);
        send_pkt(2, 0, 1'b0, 1'b0);
        chk("drop.overflow", 64'(bus.overflow), 64'd1);
        for (int k = 0; k < DEPTH; k++) pop_chk("drain");

        // Randomised traffic with interleaved pops and stray non-sop words
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.word_valid = 1'b1;
                bus.match      = 1'b1;
                bus.eop        = 1'($urandom);
                step();
                idle_in();
            end
            len = $urandom_range(1, 8);
            hit = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, len - 1));
            send_pkt(len, hit, 1'($urandom), 1'b1);
            for (int p = $urandom_range(0, 2); p > 0; p--) pop_chk("rnd_pop");
        end

        // Asynchronous reset in the middle of a hit packet
        bus.word_valid = 1'b1; bus.sop = 1'b1; bus.match = 1'b1; step();
        bus.sop = 1'b0; bus.match = 1'b0; step();
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        chk("midrst.clear", 64'(bus.clear), 64'd0);
        check_status("midrst");
        idle_in();
        step();
        step();
        n_rst = 1'b1;
        step();
        send_pkt(4, 2, 1'b0, 1'b0);
        pop_chk("post_rst_pop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
